// File: rtl/framebuffer_write_ctrl.sv
// Back-buffer write sequencer: depth-tested pixel writes, full-buffer clear sweep,
// and front/back buffer selection, all in the GPU clock domain.
//
// state      | meaning
// S_READY    | accepting pixels, 1 per cycle, into the read/compare/write pipeline
// S_DRAIN    | pipeline emptying; then pending switch, then pending clear
// S_CLEARING | writing CLEAR_Z/CLEAR_RGB to every back-buffer address
module framebuffer_write_ctrl #(
    parameter int          H_RES      = 320,
    parameter int          V_RES      = 240,
    parameter int          RD_LATENCY = 2,
    parameter logic [7:0]  CLEAR_Z    = 8'hFF,
    parameter logic [11:0] CLEAR_RGB  = 12'h000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        switch_in,
    input  logic        clear_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [8:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [7:0]  z_in,
    input  logic [11:0] rgb_in,
    output logic        front_sel_out,
    output logic [16:0] rd_addr_out,
    input  logic [7:0]  rd_z_in,
    output logic        wr_en_out,
    output logic [16:0] wr_addr_out,
    output logic [7:0]  wr_z_out,
    output logic [11:0] wr_rgb_out
);

    localparam int          NPIX      = H_RES * V_RES;
    localparam logic [16:0] LAST_ADDR = 17'(NPIX - 1);
    localparam logic [16:0] H_RES_W   = 17'(H_RES);

    typedef enum logic [1:0] {S_READY, S_DRAIN, S_CLEARING} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_front_sel;
    logic        r_pend_sw;
    logic        r_pend_clr;
    logic [16:0] r_clr_cnt;

    logic        r_pv    [0:RD_LATENCY];
    logic [16:0] r_paddr [0:RD_LATENCY];
    logic [7:0]  r_pz    [0:RD_LATENCY];
    logic [11:0] r_prgb  [0:RD_LATENCY];

    logic        r_hv    [0:RD_LATENCY-1];
    logic [16:0] r_haddr [0:RD_LATENCY-1];
    logic [7:0]  r_hz    [0:RD_LATENCY-1];

    logic        r_wr_en;
    logic [16:0] r_wr_addr;
    logic [7:0]  r_wr_z;
    logic [11:0] r_wr_rgb;

    logic        w_sw_req;
    logic        w_clr_req;
    logic        w_accept;
    logic        w_in_range;
    logic [16:0] w_pix_addr;
    logic        w_pipe_empty;
    logic [7:0]  w_fwd_z;
    logic        w_pix_wr;
    logic        w_toggle;
    logic        w_start_clear;
    logic        w_pend_sw_nxt;
    logic        w_pend_clr_nxt;

    assign w_sw_req   = r_pend_sw | switch_in;
    assign w_clr_req  = r_pend_clr | clear_in;
    assign ready_out  = (r_state == S_READY) && !r_pend_sw && !r_pend_clr;
    assign w_accept   = valid_in && ready_out;
    assign w_in_range = (int'(x_in) < H_RES) && (int'(y_in) < V_RES);
    assign w_pix_addr = 17'(y_in) * H_RES_W + 17'(x_in);

    always_comb begin
        w_pipe_empty = 1'b1;
        for (int i = 0; i <= RD_LATENCY; i++) begin
            if (r_pv[i]) w_pipe_empty = 1'b0;
        end
    end

    // Writes up to RD_LATENCY cycles old may not be reflected in rd_z_in; newest wins.
    always_comb begin
        w_fwd_z = rd_z_in;
        for (int i = RD_LATENCY - 1; i >= 0; i--) begin
            if (r_hv[i] && (r_haddr[i] == r_paddr[RD_LATENCY])) w_fwd_z = r_hz[i];
        end
        if (r_wr_en && (r_wr_addr == r_paddr[RD_LATENCY])) w_fwd_z = r_wr_z;
    end

    assign w_pix_wr = r_pv[RD_LATENCY] && (r_pz[RD_LATENCY] < w_fwd_z);

    always_comb begin
        w_state_nxt    = r_state;
        w_pend_sw_nxt  = w_sw_req;
        w_pend_clr_nxt = w_clr_req;
        w_toggle       = 1'b0;
        w_start_clear  = 1'b0;
        case (r_state)
            S_READY: begin
                if (w_sw_req || w_clr_req) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pipe_empty) begin
                    w_toggle       = w_sw_req;
                    w_pend_sw_nxt  = 1'b0;
                    w_pend_clr_nxt = 1'b0;
                    if (w_clr_req) begin
                        w_state_nxt   = S_CLEARING;
                        w_start_clear = 1'b1;
                    end else begin
                        w_state_nxt = S_READY;
                    end
                end
            end
            S_CLEARING: begin
                // Route through Drain so requests latched during the sweep get serviced.
                if (r_clr_cnt == LAST_ADDR) w_state_nxt = S_DRAIN;
            end
            default: w_state_nxt = S_READY;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= S_CLEARING;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_front_sel <= 1'b0;
            r_pend_sw   <= 1'b0;
            r_pend_clr  <= 1'b0;
            r_clr_cnt   <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) begin
                r_pv[i]    <= 1'b0;
                r_paddr[i] <= '0;
                r_pz[i]    <= '0;
                r_prgb[i]  <= '0;
            end
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_hv[i]    <= 1'b0;
                r_haddr[i] <= '0;
                r_hz[i]    <= '0;
            end
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_z    <= '0;
            r_wr_rgb  <= '0;
        end else begin
            r_pend_sw  <= w_pend_sw_nxt;
            r_pend_clr <= w_pend_clr_nxt;
            if (w_toggle) r_front_sel <= ~r_front_sel;

            if (w_start_clear)               r_clr_cnt <= '0;
            else if (r_state == S_CLEARING)  r_clr_cnt <= r_clr_cnt + 17'd1;

            r_pv[0] <= w_accept && w_in_range;
            if (w_accept && w_in_range) begin
                r_paddr[0] <= w_pix_addr;
                r_pz[0]    <= z_in;
                r_prgb[0]  <= rgb_in;
            end
            for (int i = 1; i <= RD_LATENCY; i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_paddr[i] <= r_paddr[i-1];
                r_pz[i]    <= r_pz[i-1];
                r_prgb[i]  <= r_prgb[i-1];
            end

            r_hv[0]    <= r_wr_en;
            r_haddr[0] <= r_wr_addr;
            r_hz[0]    <= r_wr_z;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_hv[i]    <= r_hv[i-1];
                r_haddr[i] <= r_haddr[i-1];
                r_hz[i]    <= r_hz[i-1];
            end

            if (r_state == S_CLEARING) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_clr_cnt;
                r_wr_z    <= CLEAR_Z;
                r_wr_rgb  <= CLEAR_RGB;
            end else if (w_pix_wr) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_paddr[RD_LATENCY];
                r_wr_z    <= r_pz[RD_LATENCY];
                r_wr_rgb  <= r_prgb[RD_LATENCY];
            end else begin
                r_wr_en <= 1'b0;
            end
        end
    end

    assign front_sel_out = r_front_sel;
    assign rd_addr_out   = r_paddr[0];
    assign wr_en_out     = r_wr_en;
    assign wr_addr_out   = r_wr_addr;
    assign wr_z_out      = r_wr_z;
    assign wr_rgb_out    = r_wr_rgb;

endmodule

// File: tb/tb_framebuffer_write_ctrl.sv
// Directed bench for framebuffer_write_ctrl at a reduced 40x30 resolution so every
// clear sweep stays short; expected addresses are y*40 + x.
module tb_framebuffer_write_ctrl;

    localparam int H  = 40;
    localparam int V  = 30;
    localparam int NP = H * V;

    logic        clk_in = 1'b0;
    logic        rst_in, switch_in, clear_in, valid_in, ready_out;
    logic [8:0]  x_in;
    logic [7:0]  y_in, z_in, rd_z_in, wr_z_out;
    logic [11:0] rgb_in, wr_rgb_out;
    logic        front_sel_out, wr_en_out;
    logic [16:0] rd_addr_out, wr_addr_out;

    int n_checks = 0;
    int n_fail   = 0;
    int g_tick   = 0;

    typedef struct {
        logic [16:0] a;
        logic [7:0]  z;
        logic [11:0] c;
        logic        f;
        int          t;
    } wr_t;
    wr_t cap_q[$];

    always #5 clk_in = ~clk_in;

    framebuffer_write_ctrl #(
        .H_RES(H), .V_RES(V), .RD_LATENCY(2), .CLEAR_Z(8'hFF), .CLEAR_RGB(12'h000)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .switch_in(switch_in), .clear_in(clear_in),
        .valid_in(valid_in), .ready_out(ready_out), .x_in(x_in), .y_in(y_in),
        .z_in(z_in), .rgb_in(rgb_in), .front_sel_out(front_sel_out),
        .rd_addr_out(rd_addr_out), .rd_z_in(rd_z_in), .wr_en_out(wr_en_out),
        .wr_addr_out(wr_addr_out), .wr_z_out(wr_z_out), .wr_rgb_out(wr_rgb_out)
    );

    // Advance to the next falling edge and log any write strobe seen there.
    task automatic tick();
        wr_t w;
        @(negedge clk_in);
        g_tick++;
        if (wr_en_out === 1'b1) begin
            w.a = wr_addr_out; w.z = wr_z_out; w.c = wr_rgb_out; w.f = front_sel_out; w.t = g_tick;
            cap_q.push_back(w);
        end
    endtask

    task automatic put_pixel(input int x, input int y, input int z, input int rgb);
        valid_in = 1'b1;
        x_in     = 9'(x);
        y_in     = 8'(y);
        z_in     = 8'(z);
        rgb_in   = 12'(rgb);
    endtask

    task automatic test_reset();
        int t0, first_rdy, errs;
        rst_in = 1'b1;
        repeat (3) tick();
        n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_out); end
        n_checks++; if (wr_en_out !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en_out); end
        n_checks++; if (front_sel_out !== 1'b0) begin n_fail++; $display("FAIL reset_front: got %b want 0", front_sel_out); end
        n_checks++; if (rd_addr_out !== 17'd0 || wr_addr_out !== 17'd0) begin
            n_fail++; $display("FAIL reset_addr: got rd=%0d wr=%0d want 0/0", rd_addr_out, wr_addr_out); end
        n_checks++; if (wr_z_out !== 8'h00 || wr_rgb_out !== 12'h000) begin
            n_fail++; $display("FAIL reset_wdata: got z=%h rgb=%h want 00/000", wr_z_out, wr_rgb_out); end
        rst_in = 1'b0;
        cap_q.delete();
        t0 = g_tick; first_rdy = 0; errs = 0;
        for (int k = 1; k <= NP + 3; k++) begin
            tick();
            if (ready_out === 1'b1 && first_rdy == 0) first_rdy = g_tick - t0;
        end
        n_checks++; if (cap_q.size() != NP) begin n_fail++; $display("FAIL init_sweep_count: got %0d want %0d", cap_q.size(), NP); end
        foreach (cap_q[i]) begin
            if (cap_q[i].a !== 17'(i) || cap_q[i].z !== 8'hFF || cap_q[i].c !== 12'h000 ||
                cap_q[i].f !== 1'b0 || cap_q[i].t - t0 != i + 1) errs++;
        end
        n_checks++; if (errs != 0) begin n_fail++; $display("FAIL init_sweep_seq: got %0d bad writes want 0", errs); end
        n_checks++; if (first_rdy != NP + 1) begin n_fail++; $display("FAIL init_ready_time: got %0d want %0d", first_rdy, NP + 1); end
    endtask

    task automatic test_single_pixel();
        int t0;
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", ready_out); end
        cap_q.delete();
        t0 = g_tick;
        put_pixel(10, 5, 'h40, 'hF00);
        tick();
        valid_in = 1'b0;
        n_checks++; if (rd_addr_out !== 17'd210) begin n_fail++; $display("FAIL single_rd_addr: got %0d want 210", rd_addr_out); end
        repeat (5) tick();
        n_checks++; if (cap_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", cap_q.size()); end
        else begin
            n_checks++; if (cap_q[0].t - t0 != 4) begin n_fail++; $display("FAIL single_latency: got %0d want 4", cap_q[0].t - t0); end
            n_checks++; if (cap_q[0].a !== 17'd210 || cap_q[0].z !== 8'h40 || cap_q[0].c !== 12'hF00) begin
                n_fail++; $display("FAIL single_data: got a=%0d z=%h rgb=%h want 210/40/F00", cap_q[0].a, cap_q[0].z, cap_q[0].c); end
        end
        n_checks++; if (wr_addr_out !== 17'd210 || wr_z_out !== 8'h40) begin
            n_fail++; $display("FAIL single_hold: got a=%0d z=%h want 210/40", wr_addr_out, wr_z_out); end
    endtask

    task automatic test_depth_compare();
        rd_z_in = 8'h30;
        cap_q.delete();
        put_pixel(3, 2, 'h40, 'h123); tick(); valid_in = 1'b0; repeat (7) tick();
        n_checks++; if (cap_q.size() != 0) begin n_fail++; $display("FAIL depth_farther: got %0d writes want 0", cap_q.size()); end
        rd_z_in = 8'h40;
        cap_q.delete();
        put_pixel(3, 2, 'h40, 'h123); tick(); valid_in = 1'b0; repeat (7) tick();
        n_checks++; if (cap_q.size() != 0) begin n_fail++; $display("FAIL depth_equal: got %0d writes want 0", cap_q.size()); end
        cap_q.delete();
        put_pixel(3, 2, 'h3F, 'h456); tick(); valid_in = 1'b0; repeat (7) tick();
        n_checks++; if (cap_q.size() != 1 || cap_q[0].a !== 17'd83 || cap_q[0].z !== 8'h3F) begin
            n_fail++; $display("FAIL depth_nearer: got %0d writes (first a=%0d) want 1 at 83", cap_q.size(), cap_q.size() > 0 ? int'(cap_q[0].a) : -1); end
        rd_z_in = 8'hFF;
    endtask

    task automatic test_boundary();
        int not_ready;
        cap_q.delete();
        not_ready = 0;
        put_pixel(40, 0, 'h01, 'hAAA); tick(); if (ready_out !== 1'b1) not_ready++;
        put_pixel(0, 30, 'h01, 'hBBB); tick(); if (ready_out !== 1'b1) not_ready++;
        put_pixel(39, 29, 'h01, 'hCCC); tick(); if (ready_out !== 1'b1) not_ready++;
        valid_in = 1'b0;
        for (int k = 0; k < 8; k++) begin tick(); if (ready_out !== 1'b1) not_ready++; end
        n_checks++; if (not_ready != 0) begin n_fail++; $display("FAIL bound_ready: got %0d low cycles want 0", not_ready); end
        n_checks++; if (cap_q.size() != 1 || cap_q[0].a !== 17'd1199 || cap_q[0].c !== 12'hCCC) begin
            n_fail++; $display("FAIL bound_writes: got %0d writes want 1 at 1199", cap_q.size()); end
    endtask

    task automatic test_back_to_back();
        cap_q.delete();
        put_pixel(10, 5, 'h40, 'hF00); tick(); put_pixel(10, 5, 'h50, 'h0F0); tick();
        valid_in = 1'b0; repeat (8) tick();
        n_checks++; if (cap_q.size() != 1 || cap_q[0].z !== 8'h40 || cap_q[0].a !== 17'd210) begin
            n_fail++; $display("FAIL b2b_fwd_suppress: got %0d writes want 1 (z=40 at 210)", cap_q.size()); end
        cap_q.delete();
        put_pixel(11, 5, 'h50, 'h00F); tick(); put_pixel(11, 5, 'h40, 'h0F0); tick();
        valid_in = 1'b0; repeat (8) tick();
        n_checks++; if (cap_q.size() != 2 || cap_q[0].z !== 8'h50 || cap_q[1].z !== 8'h40 ||
                        cap_q[1].a !== 17'd211 || cap_q[1].t - cap_q[0].t != 1) begin
            n_fail++; $display("FAIL b2b_fwd_pass: got %0d writes want 2 (z=50,z=40 consecutive at 211)", cap_q.size()); end
        cap_q.delete();
        put_pixel(12, 5, 'h40, 'h111); tick(); put_pixel(13, 5, 'h90, 'h222); tick();
        put_pixel(12, 5, 'h50, 'h333); tick();
        valid_in = 1'b0; repeat (8) tick();
        n_checks++; if (cap_q.size() != 2 || cap_q[0].a !== 17'd212 || cap_q[1].a !== 17'd213 || cap_q[1].z !== 8'h90) begin
            n_fail++; $display("FAIL b2b_fwd_gap1: got %0d writes want 2 (212 then 213)", cap_q.size()); end
        cap_q.delete();
        put_pixel(14, 5, 'h40, 'h444); tick(); valid_in = 1'b0; tick(); tick();
        put_pixel(14, 5, 'h50, 'h555); tick();
        valid_in = 1'b0; repeat (8) tick();
        n_checks++; if (cap_q.size() != 1 || cap_q[0].z !== 8'h40) begin
            n_fail++; $display("FAIL b2b_fwd_gap2: got %0d writes want 1 (z=40)", cap_q.size()); end
    endtask

    task automatic test_switch_clear_inflight();
        int t0, first_rdy, errs;
        logic f3, f4, r1;
        cap_q.delete();
        put_pixel(0, 0, 'h10, 'h111); tick();
        put_pixel(1, 0, 'h20, 'h222); tick();
        put_pixel(2, 0, 'h30, 'h333); tick();
        valid_in = 1'b0; switch_in = 1'b1; clear_in = 1'b1;
        t0 = g_tick; first_rdy = 0; f3 = 1'bx; f4 = 1'bx; r1 = 1'bx;
        for (int k = 1; k <= NP + 8; k++) begin
            tick();
            switch_in = 1'b0; clear_in = 1'b0;
            if (k == 1) r1 = ready_out;
            if (k == 3) f3 = front_sel_out;
            if (k == 4) f4 = front_sel_out;
            if (ready_out === 1'b1 && first_rdy == 0) first_rdy = k;
        end
        n_checks++; if (r1 !== 1'b0) begin n_fail++; $display("FAIL sc_ready_fall: got %b want 0", r1); end
        n_checks++; if (f3 !== 1'b0 || f4 !== 1'b1) begin n_fail++; $display("FAIL sc_toggle_time: got %b%b want 01", f3, f4); end
        n_checks++; if (cap_q.size() != NP + 3) begin n_fail++; $display("FAIL sc_write_count: got %0d want %0d", cap_q.size(), NP + 3); end
        errs = 0;
        foreach (cap_q[i]) begin
            if (i < 3) begin
                if (cap_q[i].a !== 17'(i) || cap_q[i].z !== 8'((i + 1) * 16) || cap_q[i].f !== 1'b0 ||
                    cap_q[i].t - t0 != i + 1) errs++;
            end else begin
                if (cap_q[i].a !== 17'(i - 3) || cap_q[i].z !== 8'hFF || cap_q[i].c !== 12'h000 ||
                    cap_q[i].f !== 1'b1 || cap_q[i].t - t0 != i + 2) errs++;
            end
        end
        n_checks++; if (errs != 0) begin n_fail++; $display("FAIL sc_write_seq: got %0d bad writes want 0", errs); end
        n_checks++; if (first_rdy != NP + 5) begin n_fail++; $display("FAIL sc_ready_time: got %0d want %0d", first_rdy, NP + 5); end
    endtask

    task automatic test_switch_during_clear();
        int t0, first_rdy, errs;
        logic f_pre, f_post;
        cap_q.delete();
        clear_in = 1'b1;
        t0 = g_tick; first_rdy = 0; f_pre = 1'bx; f_post = 1'bx;
        for (int k = 1; k <= NP + 8; k++) begin
            tick();
            clear_in  = 1'b0;
            switch_in = (k == 100);
            if (k >= 200 && k < 206) put_pixel(5, 5, 'h00, 'hEEE);
            else valid_in = 1'b0;
            if (k == NP + 2) f_pre = front_sel_out;
            if (k == NP + 3) f_post = front_sel_out;
            if (ready_out === 1'b1 && first_rdy == 0) first_rdy = k;
        end
        n_checks++; if (cap_q.size() != NP) begin n_fail++; $display("FAIL sdc_write_count: got %0d want %0d", cap_q.size(), NP); end
        errs = 0;
        foreach (cap_q[i]) begin
            if (cap_q[i].a !== 17'(i) || cap_q[i].z !== 8'hFF || cap_q[i].f !== 1'b1 ||
                cap_q[i].t - t0 != i + 3) errs++;
        end
        n_checks++; if (errs != 0) begin n_fail++; $display("FAIL sdc_write_seq: got %0d bad writes want 0", errs); end
        n_checks++; if (f_pre !== 1'b1 || f_post !== 1'b0) begin n_fail++; $display("FAIL sdc_toggle: got %b%b want 10", f_pre, f_post); end
        n_checks++; if (first_rdy != NP + 3) begin n_fail++; $display("FAIL sdc_ready_time: got %0d want %0d", first_rdy, NP + 3); end
    endtask

    initial begin
        rst_in = 1'b1; switch_in = 1'b0; clear_in = 1'b0; valid_in = 1'b0;
        x_in = '0; y_in = '0; z_in = '0; rgb_in = '0; rd_z_in = 8'hFF;
        test_reset();
        test_single_pixel();
        test_depth_compare();
        test_boundary();
        test_back_to_back();
        test_switch_clear_inflight();
        test_switch_during_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
